// File: rtl/fetch_hazard_ctrl.sv
// rtl/fetch_hazard_ctrl.sv - fetch-stage PC select and pipeline hazard control
// Arbitrates redirect, load-use, and I-mem wait each cycle, and counts stall and flush events.
module fetch_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        jal_e,
    input  logic        jalr_e,
    input  logic        branch_taken_e,
    input  logic        mispredict_e,
    input  logic [31:0] alu_result_e,
    input  logic [31:0] pc_back_e,
    input  logic        mem_read_e,
    input  logic [4:0]  rd_e,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic        pred_valid_f,
    input  logic [31:0] pred_addr_f,
    input  logic        imem_ready,
    input  logic        clr_cnt,
    output logic [1:0]  pc_sel,
    output logic [31:0] pc_redirect,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_d,
    output logic        flush_e,
    output logic [1:0]  state,
    output logic [15:0] cnt_stall,
    output logic [15:0] cnt_flush
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_FLUSH = 2'b01,
        ST_WAIT  = 2'b10,
        ST_BAD   = 2'b11
    } state_t;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_PRED = 2'b01;
    localparam logic [1:0] PC_REDIR = 2'b10;
    localparam logic [1:0] PC_HOLD = 2'b11;

    state_t      state_q, state_d;
    logic [15:0] cnt_stall_q, cnt_stall_d;
    logic [15:0] cnt_flush_q, cnt_flush_d;
    logic        redirect;
    logic        load_use;

    // The predicted target is muxed in by the PC register itself; only its valid bit matters here.
    logic unused_pred_addr;
    assign unused_pred_addr = ^pred_addr_f;

    assign redirect = jal_e | jalr_e | branch_taken_e | mispredict_e;
    assign load_use = mem_read_e & (rd_e != 5'd0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
    assign pc_redirect = rst ? 32'd0 : (mispredict_e ? pc_back_e : alu_result_e);

    always_comb begin
        pc_sel  = PC_SEQ;
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        state_d = state_q;
        if (redirect) begin
            pc_sel  = PC_REDIR;
            flush_d = 1'b1;
            flush_e = 1'b1;
            state_d = ST_FLUSH;
        end else if (load_use) begin
            pc_sel  = PC_HOLD;
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            if (state_q == ST_BAD) begin
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    flush_d = 1'b1;
                    if (imem_ready) begin
                        state_d = ST_RUN;
                    end else begin
                        pc_sel = PC_HOLD;
                    end
                end
                default: begin
                    if (!imem_ready) begin
                        pc_sel  = PC_HOLD;
                        stall_f = 1'b1;
                        flush_d = 1'b1;
                        state_d = (state_q == ST_BAD) ? ST_RUN : ST_WAIT;
                    end else begin
                        pc_sel  = pred_valid_f ? PC_PRED : PC_SEQ;
                        state_d = ST_RUN;
                    end
                end
            endcase
        end
        // Reset holds the pipeline flushed so nothing stale escapes before the first real fetch.
        if (rst) begin
            pc_sel  = PC_SEQ;
            stall_f = 1'b0;
            stall_d = 1'b0;
            flush_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_comb begin
        cnt_stall_d = cnt_stall_q;
        cnt_flush_d = cnt_flush_q;
        if (clr_cnt) begin
            cnt_stall_d = 16'd0;
            cnt_flush_d = 16'd0;
        end else begin
            if (stall_f && (cnt_stall_q != 16'hFFFF)) begin
                cnt_stall_d = cnt_stall_q + 16'd1;
            end
            if (redirect && (cnt_flush_q != 16'hFFFF)) begin
                cnt_flush_d = cnt_flush_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_stall_q <= 16'd0;
            cnt_flush_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_stall_q <= cnt_stall_d;
            cnt_flush_q <= cnt_flush_d;
        end
    end

    assign state     = state_q;
    assign cnt_stall = cnt_stall_q;
    assign cnt_flush = cnt_flush_q;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// tb/tb_fetch_hazard_ctrl.sv - scoreboard bench for fetch_hazard_ctrl
// Expected control vectors are queued as stimulus is applied and popped when outputs settle.
module tb_fetch_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        jal_e, jalr_e, branch_taken_e, mispredict_e;
    logic [31:0] alu_result_e, pc_back_e;
    logic        mem_read_e;
    logic [4:0]  rd_e, rs1_d, rs2_d;
    logic        pred_valid_f;
    logic [31:0] pred_addr_f;
    logic        imem_ready, clr_cnt;
    logic [1:0]  pc_sel;
    logic [31:0] pc_redirect;
    logic        stall_f, stall_d, flush_d, flush_e;
    logic [1:0]  state;
    logic [15:0] cnt_stall, cnt_flush;

    fetch_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .jal_e(jal_e), .jalr_e(jalr_e), .branch_taken_e(branch_taken_e), .mispredict_e(mispredict_e),
        .alu_result_e(alu_result_e), .pc_back_e(pc_back_e),
        .mem_read_e(mem_read_e), .rd_e(rd_e), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .pred_valid_f(pred_valid_f), .pred_addr_f(pred_addr_f),
        .imem_ready(imem_ready), .clr_cnt(clr_cnt),
        .pc_sel(pc_sel), .pc_redirect(pc_redirect),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .state(state), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp = {pc_sel[1:0], stall_f, stall_d, flush_d, flush_e, state[1:0]}
    typedef struct packed {
        logic        rst, jal, jalr, bt, mp, mr;
        logic [4:0]  rd, rs1, rs2;
        logic        pred, rdy, clr;
        logic [7:0]  exp;
        logic [31:0] pcr;
    } vec_t;

    wire [7:0] ctl = {pc_sel, stall_f, stall_d, flush_d, flush_e, state};

    vec_t        sb[$];
    int          checks_total  = 0;
    int          checks_passed = 0;
    logic [15:0] m_stall = 16'd0;
    logic [15:0] m_flush = 16'd0;

    function automatic vec_t mk(input logic r, input logic j, input logic jr, input logic b,
                                input logic m, input logic mr, input logic [4:0] rd,
                                input logic [4:0] r1, input logic [4:0] r2, input logic p,
                                input logic rdy, input logic c, input logic [7:0] e,
                                input logic [31:0] pcr);
        vec_t v;
        v.rst = r; v.jal = j; v.jalr = jr; v.bt = b; v.mp = m; v.mr = mr;
        v.rd = rd; v.rs1 = r1; v.rs2 = r2; v.pred = p; v.rdy = rdy; v.clr = c;
        v.exp = e; v.pcr = pcr;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        rst = v.rst; jal_e = v.jal; jalr_e = v.jalr; branch_taken_e = v.bt; mispredict_e = v.mp;
        mem_read_e = v.mr; rd_e = v.rd; rs1_d = v.rs1; rs2_d = v.rs2;
        pred_valid_f = v.pred; imem_ready = v.rdy; clr_cnt = v.clr;
    endtask

    task automatic model_step(input vec_t e);
        if (e.rst || e.clr) begin
            m_stall = 16'd0;
            m_flush = 16'd0;
        end else begin
            if (e.exp[5] && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (e.exp[7:6] == 2'b10 && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
        end
    endtask

    task automatic test_reset;
        vec_t v[$];
        vec_t e;
        alu_result_e = 32'h40; pc_back_e = 32'h0;
        v.push_back(mk(1,1,0,0,0,0,0,0,0,0,1,0, 8'b00_0011_00, 32'h0));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,0, 8'b00_0000_00, 32'h40));
        for (int i = 0; i < v.size(); i++) begin
            @(negedge clk);
            checks_total++;
            if (cnt_stall !== m_stall || cnt_flush !== m_flush)
                $display("FAIL reset[%0d] counters: got %h/%h want %h/%h", i, cnt_stall, cnt_flush, m_stall, m_flush);
            else checks_passed++;
            apply(v[i]);
            sb.push_back(v[i]);
            #1;
            e = sb.pop_front();
            checks_total++;
            if (ctl !== e.exp || pc_redirect !== e.pcr)
                $display("FAIL reset[%0d] ctl/pcr: got %b/%h want %b/%h", i, ctl, pc_redirect, e.exp, e.pcr);
            else checks_passed++;
            model_step(e);
        end
    endtask

    task automatic test_jal;
        vec_t v[$];
        vec_t e;
        alu_result_e = 32'h40; pc_back_e = 32'h0;
        v.push_back(mk(0,1,0,0,0,0,0,0,0,0,1,0, 8'b10_0011_00, 32'h40));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,0, 8'b00_0010_01, 32'h40));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,1,1,0, 8'b01_0000_00, 32'h40));
        v.push_back(mk(0,0,1,0,0,0,0,0,0,0,1,0, 8'b10_0011_00, 32'h40));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,0, 8'b00_0010_01, 32'h40));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,0, 8'b00_0000_00, 32'h40));
        for (int i = 0; i < v.size(); i++) begin
            @(negedge clk);
            checks_total++;
            if (cnt_stall !== m_stall || cnt_flush !== m_flush)
                $display("FAIL jal[%0d] counters: got %h/%h want %h/%h", i, cnt_stall, cnt_flush, m_stall, m_flush);
            else checks_passed++;
            apply(v[i]);
            sb.push_back(v[i]);
            #1;
            e = sb.pop_front();
            checks_total++;
            if (ctl !== e.exp || pc_redirect !== e.pcr)
                $display("FAIL jal[%0d] ctl/pcr: got %b/%h want %b/%h", i, ctl, pc_redirect, e.exp, e.pcr);
            else checks_passed++;
            model_step(e);
        end
    endtask

    task automatic test_load_use;
        vec_t v[$];
        vec_t e;
        alu_result_e = 32'h0; pc_back_e = 32'h0;
        v.push_back(mk(0,0,0,0,0,1,5,0,5,0,1,0, 8'b11_1101_00, 32'h0));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,0, 8'b00_0000_00, 32'h0));
        v.push_back(mk(0,0,0,0,0,1,0,0,0,0,1,0, 8'b00_0000_00, 32'h0));
        v.push_back(mk(0,0,0,0,0,1,7,7,3,1,1,0, 8'b11_1101_00, 32'h0));
        v.push_back(mk(0,0,0,0,0,0,7,7,0,0,1,0, 8'b00_0000_00, 32'h0));
        v.push_back(mk(0,0,0,0,0,1,7,7,0,0,0,0, 8'b11_1101_00, 32'h0));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,0, 8'b00_0000_00, 32'h0));
        for (int i = 0; i < v.size(); i++) begin
            @(negedge clk);
            checks_total++;
            if (cnt_stall !== m_stall || cnt_flush !== m_flush)
                $display("FAIL load_use[%0d] counters: got %h/%h want %h/%h", i, cnt_stall, cnt_flush, m_stall, m_flush);
            else checks_passed++;
            apply(v[i]);
            sb.push_back(v[i]);
            #1;
            e = sb.pop_front();
            checks_total++;
            if (ctl !== e.exp || pc_redirect !== e.pcr)
                $display("FAIL load_use[%0d] ctl/pcr: got %b/%h want %b/%h", i, ctl, pc_redirect, e.exp, e.pcr);
            else checks_passed++;
            model_step(e);
        end
    endtask

    task automatic test_mispredict;
        vec_t v[$];
        vec_t e;
        alu_result_e = 32'h200; pc_back_e = 32'h100;
        v.push_back(mk(0,0,0,1,1,1,3,3,0,0,1,0, 8'b10_0011_00, 32'h100));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 8'b11_0010_01, 32'h200));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 8'b11_0010_01, 32'h200));
        v.push_back(mk(0,0,0,0,0,1,3,3,0,0,1,0, 8'b11_1101_01, 32'h200));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,0, 8'b00_0010_01, 32'h200));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,1,1,0, 8'b01_0000_00, 32'h200));
        for (int i = 0; i < v.size(); i++) begin
            @(negedge clk);
            checks_total++;
            if (cnt_stall !== m_stall || cnt_flush !== m_flush)
                $display("FAIL mispredict[%0d] counters: got %h/%h want %h/%h", i, cnt_stall, cnt_flush, m_stall, m_flush);
            else checks_passed++;
            apply(v[i]);
            sb.push_back(v[i]);
            #1;
            e = sb.pop_front();
            checks_total++;
            if (ctl !== e.exp || pc_redirect !== e.pcr)
                $display("FAIL mispredict[%0d] ctl/pcr: got %b/%h want %b/%h", i, ctl, pc_redirect, e.exp, e.pcr);
            else checks_passed++;
            model_step(e);
        end
    endtask

    task automatic test_imem_wait;
        vec_t v[$];
        vec_t e;
        alu_result_e = 32'h80; pc_back_e = 32'h0;
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 8'b11_1010_00, 32'h80));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 8'b11_1010_10, 32'h80));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 8'b11_1010_10, 32'h80));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,1,1,0, 8'b01_0000_10, 32'h80));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,0, 8'b00_0000_00, 32'h80));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 8'b11_1010_00, 32'h80));
        v.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,0, 8'b10_0011_10, 32'h80));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 8'b11_0010_01, 32'h80));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 8'b11_0010_01, 32'h80));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,0, 8'b00_0010_01, 32'h80));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,0, 8'b00_0000_00, 32'h80));
        for (int i = 0; i < v.size(); i++) begin
            @(negedge clk);
            checks_total++;
            if (cnt_stall !== m_stall || cnt_flush !== m_flush)
                $display("FAIL imem_wait[%0d] counters: got %h/%h want %h/%h", i, cnt_stall, cnt_flush, m_stall, m_flush);
            else checks_passed++;
            apply(v[i]);
            sb.push_back(v[i]);
            #1;
            e = sb.pop_front();
            checks_total++;
            if (ctl !== e.exp || pc_redirect !== e.pcr)
                $display("FAIL imem_wait[%0d] ctl/pcr: got %b/%h want %b/%h", i, ctl, pc_redirect, e.exp, e.pcr);
            else checks_passed++;
            model_step(e);
        end
    endtask

    task automatic test_reset_mid_state;
        vec_t v[$];
        vec_t e;
        alu_result_e = 32'h80; pc_back_e = 32'h0;
        v.push_back(mk(0,1,0,0,0,0,0,0,0,0,1,0, 8'b10_0011_00, 32'h80));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 8'b11_0010_01, 32'h80));
        v.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 8'b00_0011_01, 32'h0));
        v.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 8'b00_0011_00, 32'h0));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,0, 8'b00_0000_00, 32'h80));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 8'b11_1010_00, 32'h80));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 8'b11_1010_10, 32'h80));
        v.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 8'b00_0011_10, 32'h0));
        v.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,0, 8'b00_0000_00, 32'h80));
        for (int i = 0; i < v.size(); i++) begin
            @(negedge clk);
            checks_total++;
            if (cnt_stall !== m_stall || cnt_flush !== m_flush)
                $display("FAIL reset_mid[%0d] counters: got %h/%h want %h/%h", i, cnt_stall, cnt_flush, m_stall, m_flush);
            else checks_passed++;
            apply(v[i]);
            sb.push_back(v[i]);
            #1;
            e = sb.pop_front();
            checks_total++;
            if (ctl !== e.exp || pc_redirect !== e.pcr)
                $display("FAIL reset_mid[%0d] ctl/pcr: got %b/%h want %b/%h", i, ctl, pc_redirect, e.exp, e.pcr);
            else checks_passed++;
            model_step(e);
        end
    endtask

    task automatic test_saturation;
        vec_t lu;
        vec_t lu_clr;
        int   n;
        lu     = mk(0,0,0,0,0,1,5,5,0,0,1,0, 8'b11_1101_00, 32'h0);
        lu_clr = mk(0,0,0,0,0,1,5,5,0,0,1,1, 8'b11_1101_00, 32'h0);
        n = 32'hFFFE - int'(m_stall);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            apply(lu);
        end
        @(negedge clk);
        checks_total++;
        if (cnt_stall !== 16'hFFFE)
            $display("FAIL sat_pre cnt_stall: got %h want fffe", cnt_stall);
        else checks_passed++;
        for (int i = 0; i < 3; i++) begin
            apply(lu);
            @(negedge clk);
        end
        checks_total++;
        if (cnt_stall !== 16'hFFFF)
            $display("FAIL sat_hold cnt_stall: got %h want ffff", cnt_stall);
        else checks_passed++;
        apply(lu_clr);
        #1;
        checks_total++;
        if (stall_f !== 1'b1)
            $display("FAIL sat_clr stall_f: got %b want 1", stall_f);
        else checks_passed++;
        @(negedge clk);
        checks_total++;
        if (cnt_stall !== 16'h0 || cnt_flush !== 16'h0)
            $display("FAIL sat_clr counters: got %h/%h want 0000/0000", cnt_stall, cnt_flush);
        else checks_passed++;
        m_stall = 16'd0;
        m_flush = 16'd0;
        apply(mk(0,0,0,0,0,0,0,0,0,0,1,0, 8'b00_0000_00, 32'h0));
        @(negedge clk);
        checks_total++;
        if (cnt_stall !== 16'h0)
            $display("FAIL post_clr cnt_stall: got %h want 0000", cnt_stall);
        else checks_passed++;
    endtask

    initial begin
        rst = 1'b1; jal_e = 1'b0; jalr_e = 1'b0; branch_taken_e = 1'b0; mispredict_e = 1'b0;
        alu_result_e = 32'h0; pc_back_e = 32'h0; mem_read_e = 1'b0;
        rd_e = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
        pred_valid_f = 1'b0; pred_addr_f = 32'h1000; imem_ready = 1'b1; clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_jal();
        test_load_use();
        test_mispredict();
        test_imem_wait();
        test_reset_mid_state();
        test_saturation();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
